// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
// Merges line-accelerator writes, single CPU pixel writes and a full-frame fill engine into one
// registered frame buffer write port. Fixed priority: accelerator > CPU holding register > fill.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   xl_wr_en_i/addr_i/data_i     accelerator write (no backpressure, always taken)
//   cpu_wr_valid_i/ready_o       CPU single-pixel write handshake
//   cpu_wr_addr_i/data_i         CPU pixel address and data
//   fill_valid_i/ready_o         full-frame fill start handshake
//   fill_color_i                 fill value, captured when the fill is accepted
//   busy_o                       fill running, CPU write held, or output write pending
//   fb_wr_en_o/addr_o/data_o     registered frame buffer write port
module framebuffer_write_arbiter #(
    parameter int unsigned MemWidth     = 1,
    parameter int unsigned MemDepth     = 786432,
    parameter int unsigned MemAddrWidth = $clog2(MemDepth)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    xl_wr_en_i,
    input  logic [MemWidth-1:0]     xl_wr_data_i,
    input  logic [MemAddrWidth-1:0] xl_wr_addr_i,
    input  logic                    cpu_wr_valid_i,
    output logic                    cpu_wr_ready_o,
    input  logic [MemAddrWidth-1:0] cpu_wr_addr_i,
    input  logic [MemWidth-1:0]     cpu_wr_data_i,
    input  logic                    fill_valid_i,
    output logic                    fill_ready_o,
    input  logic [MemWidth-1:0]     fill_color_i,
    output logic                    busy_o,
    output logic                    fb_wr_en_o,
    output logic [MemAddrWidth-1:0] fb_wr_addr_o,
    output logic [MemWidth-1:0]     fb_wr_data_o
);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    // Depth need not be a power of two, so the last address is compared explicitly.
    localparam logic [MemAddrWidth-1:0] LastAddr = MemAddrWidth'(MemDepth - 1);

    state_e                  state_q, state_d;
    logic [MemAddrWidth-1:0] fill_addr_q, fill_addr_d;
    logic [MemWidth-1:0]     fill_color_q, fill_color_d;
    logic                    hold_v_q, hold_v_d;
    logic [MemAddrWidth-1:0] hold_addr_q, hold_addr_d;
    logic [MemWidth-1:0]     hold_data_q, hold_data_d;
    logic                    fb_wr_en_q, fb_wr_en_d;
    logic [MemAddrWidth-1:0] fb_wr_addr_q, fb_wr_addr_d;
    logic [MemWidth-1:0]     fb_wr_data_q, fb_wr_data_d;

    logic cpu_accept;
    logic fill_accept;

    assign cpu_wr_ready_o = !hold_v_q && (state_q == StIdle);
    assign fill_ready_o   = !hold_v_q && (state_q == StIdle);
    assign cpu_accept     = cpu_wr_valid_i && cpu_wr_ready_o;
    assign fill_accept    = fill_valid_i && fill_ready_o;

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        hold_v_d     = hold_v_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        fb_wr_en_d   = 1'b0;
        fb_wr_addr_d = fb_wr_addr_q;
        fb_wr_data_d = fb_wr_data_q;

        // One output slot per cycle, accelerator first.
        if (xl_wr_en_i) begin
            fb_wr_en_d   = 1'b1;
            fb_wr_addr_d = xl_wr_addr_i;
            fb_wr_data_d = xl_wr_data_i;
        end else if (hold_v_q) begin
            fb_wr_en_d   = 1'b1;
            fb_wr_addr_d = hold_addr_q;
            fb_wr_data_d = hold_data_q;
            hold_v_d     = 1'b0;
        end else if (state_q == StFill) begin
            fb_wr_en_d   = 1'b1;
            fb_wr_addr_d = fill_addr_q;
            fb_wr_data_d = fill_color_q;
            if (fill_addr_q == LastAddr) begin
                state_d     = StIdle;
                fill_addr_d = '0;
            end else begin
                fill_addr_d = fill_addr_q + MemAddrWidth'(1);
            end
        end

        // Acceptance only happens with hold_v_q clear, so it never collides with a drain.
        if (cpu_accept) begin
            hold_v_d    = 1'b1;
            hold_addr_d = cpu_wr_addr_i;
            hold_data_d = cpu_wr_data_i;
        end

        // Acceptance only happens in StIdle, so it never collides with an emit.
        if (fill_accept) begin
            state_d      = StFill;
            fill_addr_d  = '0;
            fill_color_d = fill_color_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            fill_addr_q  <= '0;
            fill_color_q <= '0;
            hold_v_q     <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            fb_wr_en_q   <= 1'b0;
            fb_wr_addr_q <= '0;
            fb_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            hold_v_q     <= hold_v_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            fb_wr_en_q   <= fb_wr_en_d;
            fb_wr_addr_q <= fb_wr_addr_d;
            fb_wr_data_q <= fb_wr_data_d;
        end
    end

    assign busy_o       = (state_q == StFill) || hold_v_q || fb_wr_en_q;
    assign fb_wr_en_o   = fb_wr_en_q;
    assign fb_wr_addr_o = fb_wr_addr_q;
    assign fb_wr_data_o = fb_wr_data_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Bench for framebuffer_write_arbiter with a 16-word, 4-bit frame buffer.
module tb_framebuffer_write_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          xl_en = 1'b0;
    logic [W-1:0]  xl_data = '0;
    logic [AW-1:0] xl_addr = '0;
    logic          cpu_valid = 1'b0;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr = '0;
    logic [W-1:0]  cpu_data = '0;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    logic [W-1:0]  fill_color = '0;
    logic          busy;
    logic          fb_en;
    logic [AW-1:0] fb_addr;
    logic [W-1:0]  fb_data;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    framebuffer_write_arbiter #(
        .MemWidth (W),
        .MemDepth (D)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .xl_wr_en_i     (xl_en),
        .xl_wr_data_i   (xl_data),
        .xl_wr_addr_i   (xl_addr),
        .cpu_wr_valid_i (cpu_valid),
        .cpu_wr_ready_o (cpu_ready),
        .cpu_wr_addr_i  (cpu_addr),
        .cpu_wr_data_i  (cpu_data),
        .fill_valid_i   (fill_valid),
        .fill_ready_o   (fill_ready),
        .fill_color_i   (fill_color),
        .busy_o         (busy),
        .fb_wr_en_o     (fb_en),
        .fb_wr_addr_o   (fb_addr),
        .fb_wr_data_o   (fb_data)
    );

    typedef struct {
        logic          xl;
        logic [AW-1:0] xa;
        logic [W-1:0]  xd;
        logic          cv;
        logic [AW-1:0] ca;
        logic [W-1:0]  cd;
        logic          fv;
        logic [W-1:0]  fc;
        logic          en;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic          crdy;
        logic          frdy;
        logic          bsy;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        xl_en      = 1'b0;
        cpu_valid  = 1'b0;
        fill_valid = 1'b0;
    endtask

    task automatic check_fb(input string name, input logic en, input logic [AW-1:0] a,
                            input logic [W-1:0] d);
        check({name, ".en"}, 32'(fb_en), 32'(en));
        if (en) begin
            check({name, ".addr"}, 32'(fb_addr), 32'(a));
            check({name, ".data"}, 32'(fb_data), 32'(d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: inputs applied for one cycle, outputs checked just after the edge.
        //             xl  xa    xd    cv  ca     cd    fv  fc    en  a      d     crdy frdy bsy
        vecs[0]  = '{1'b1, 4'd5, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'd0, 4'd4, 1'b1, 4'd12, 4'd3, 1'b0, 4'd0, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 4'd5, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 4'd2, 4'd6, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd6, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd12, 4'd3, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        // fill_valid while the holding register is full must be ignored
        vecs[9]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 4'd9, 4'd2, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_fb("reset", 1'b0, '0, '0);
        check("reset.addr", 32'(fb_addr), 32'd0);
        check("reset.data", 32'(fb_data), 32'd0);
        check("reset.cpu_ready", 32'(cpu_ready), 32'd1);
        check("reset.fill_ready", 32'(fill_ready), 32'd1);
        check("reset.busy", 32'(busy), 32'd0);

        for (int i = 0; i < 11; i++) begin
            xl_en      = vecs[i].xl;
            xl_addr    = vecs[i].xa;
            xl_data    = vecs[i].xd;
            cpu_valid  = vecs[i].cv;
            cpu_addr   = vecs[i].ca;
            cpu_data   = vecs[i].cd;
            fill_valid = vecs[i].fv;
            fill_color = vecs[i].fc;
            tick();
            check_fb($sformatf("vec%0d", i), vecs[i].en, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d.cpu_ready", i), 32'(cpu_ready), 32'(vecs[i].crdy));
            check($sformatf("vec%0d.fill_ready", i), 32'(fill_ready), 32'(vecs[i].frdy));
            check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
        end
        idle_inputs();

        // Plain fill: 16 writes of color A, fill_ready low until the last one.
        fill_valid = 1'b1;
        fill_color = 4'hA;
        tick();
        idle_inputs();
        check_fb("fill1.accept", 1'b0, '0, '0);
        check("fill1.accept.fill_ready", 32'(fill_ready), 32'd0);
        check("fill1.accept.busy", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check_fb($sformatf("fill1.w%0d", k), 1'b1, AW'(k), 4'hA);
            check($sformatf("fill1.w%0d.fill_ready", k), 32'(fill_ready), (k == 15) ? 32'd1 : 32'd0);
        end
        tick();
        check_fb("fill1.after", 1'b0, '0, '0);
        check("fill1.after.busy", 32'(busy), 32'd0);

        // Fill with one accelerator write inserted before fill address 7.
        fill_valid = 1'b1;
        fill_color = 4'h5;
        tick();
        idle_inputs();
        for (int k = 0; k < 7; k++) begin
            tick();
            check_fb($sformatf("fill2.w%0d", k), 1'b1, AW'(k), 4'h5);
        end
        xl_en   = 1'b1;
        xl_addr = 4'd3;
        xl_data = 4'hC;
        tick();
        xl_en = 1'b0;
        check_fb("fill2.xl", 1'b1, 4'd3, 4'hC);
        for (int k = 7; k < 16; k++) begin
            tick();
            check_fb($sformatf("fill2.w%0d", k), 1'b1, AW'(k), 4'h5);
        end
        tick();
        check_fb("fill2.after", 1'b0, '0, '0);

        // CPU and fill accepted together: CPU first, then the fill; CPU blocked during fill.
        cpu_valid  = 1'b1;
        cpu_addr   = 4'd2;
        cpu_data   = 4'h9;
        fill_valid = 1'b1;
        fill_color = 4'h6;
        tick();
        fill_valid = 1'b0;
        cpu_addr   = 4'd4;
        cpu_data   = 4'h1;
        check_fb("both.accept", 1'b0, '0, '0);
        check("both.accept.cpu_ready", 32'(cpu_ready), 32'd0);
        tick();
        check_fb("both.cpu", 1'b1, 4'd2, 4'h9);
        for (int k = 0; k < 16; k++) begin
            tick();
            check_fb($sformatf("both.w%0d", k), 1'b1, AW'(k), 4'h6);
            if (k < 15) begin
                check($sformatf("both.w%0d.cpu_ready", k), 32'(cpu_ready), 32'd0);
            end
        end
        check("both.end.cpu_ready", 32'(cpu_ready), 32'd1);
        tick();
        cpu_valid = 1'b0;
        check_fb("both.cpu2.accept", 1'b0, '0, '0);
        tick();
        check_fb("both.cpu2", 1'b1, 4'd4, 4'h1);
        tick();

        // Reset in the middle of a fill.
        fill_valid = 1'b1;
        fill_color = 4'hF;
        tick();
        idle_inputs();
        for (int k = 0; k < 9; k++) begin
            tick();
            check_fb($sformatf("rst.w%0d", k), 1'b1, AW'(k), 4'hF);
        end
        rst = 1'b1;
        #1;
        check("rst.async.en", 32'(fb_en), 32'd0);
        check("rst.async.fill_ready", 32'(fill_ready), 32'd1);
        check("rst.async.cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst.async.busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        begin
            int writes = 0;
            for (int k = 0; k < 24; k++) begin
                tick();
                if (fb_en) writes++;
            end
            check("rst.no_writes", 32'(writes), 32'd0);
        end
        check("rst.end.fill_ready", 32'(fill_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
